// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core encodings and vector constants
package mips_pkg;

  // Controller PCSrc encodings
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JR     = 2'b11
  } pc_src_e;

  // Fixed entry points; bit 31 set means they all run in kernel mode
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] XADR_PC  = 32'h8000_0008;

  // $k0 receives the interrupt link; matches the controller's RegDst=11 target
  localparam logic [4:0] K0_REG = 5'd26;

endpackage

// File: rtl/irq_pending.sv
// rtl/irq_pending.sv - interrupt request edge detect and pending flag
import mips_pkg::*;

module irq_pending (
  input  logic clk,
  input  logic reset,
  input  logic irq_req,
  input  logic take,
  output logic pending
);

  logic r_irq_req_d;
  logic r_pending;
  logic w_rise;

  // A level held high only counts once; a new request needs low then high
  assign w_rise = irq_req & ~r_irq_req_d;

  // Delay register for edge detect; set beats clear when both happen together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_req_d <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      r_irq_req_d <= irq_req;
      if (w_rise)
        r_pending <= 1'b1;
      else if (take)
        r_pending <= 1'b0;
    end
  end

  assign pending = r_pending;

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter, next-PC select and interrupt take
import mips_pkg::*;

module pc_unit #(
  parameter logic [31:0] P_RESET_PC = RESET_PC,
  parameter logic [31:0] P_ILLOP_PC = ILLOP_PC,
  parameter logic [31:0] P_XADR_PC  = XADR_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_en,
  input  logic        irq_req,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic        undefined_inst,
  input  logic [15:0] imm16,
  input  logic [25:0] jump_target,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        irq
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [30:0] w_br_off;
  logic [30:0] w_br_sum;
  logic [31:0] w_next_pc;
  logic        w_pending;
  logic        w_irq;
  logic        w_take;

  // Supervisor bit never carries: only the low 31 bits increment
  assign w_pc_plus4 = {r_pc[31], r_pc[30:0] + 31'd4};

  // Branch offset sign-extended and word-scaled, kept to 31 bits so mode is preserved
  assign w_br_off = {{13{imm16[15]}}, imm16, 2'b00};
  assign w_br_sum = w_pc_plus4[30:0] + w_br_off;

  // Interrupts only fire in user mode; purely from registered state
  assign w_irq  = w_pending & ~r_pc[31];
  assign w_take = w_irq & pc_en;

  irq_pending u_irq_pending (
    .clk     (clk),
    .reset   (reset),
    .irq_req (irq_req),
    .take    (w_take),
    .pending (w_pending)
  );

  // Next-PC select: interrupt, then illegal op, then controller PCSrc
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_irq) begin
      w_next_pc = P_XADR_PC;
    end else if (undefined_inst) begin
      w_next_pc = P_ILLOP_PC;
    end else begin
      case (pc_src)
        PC_SEQ:    w_next_pc = w_pc_plus4;
        PC_BRANCH: w_next_pc = branch_taken ? {r_pc[31], w_br_sum} : w_pc_plus4;
        PC_JUMP:   w_next_pc = {w_pc_plus4[31:28], jump_target, 2'b00};
        PC_JR:     w_next_pc = {r_pc[31] & rs_data[31], rs_data[30:0]};
        default:   w_next_pc = w_pc_plus4;
      endcase
    end
  end

  // PC register; holds while pc_en is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_pc <= P_RESET_PC;
    else if (pc_en)
      r_pc <= w_next_pc;
  end

  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign irq      = w_irq;

endmodule
